// File: rtl/btn_debounce_array.sv
// Per-channel button debouncer with optional auto-repeat: 2-flop sync, stability counter, repeat FSM.
// Latency: a settled input change appears on level_o/press_o/release_o STABLE_CYCLES+2 edges later.
// Backpressure: none; pulses are single-cycle events with no handshake.
module btn_debounce_array #(
    parameter int N_CH          = 5,
    parameter int STABLE_CYCLES = 500000,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] repeat_o,
    output logic            any_press_o
);

    localparam int SW   = $clog2(STABLE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);

    localparam logic [SW-1:0] STABLE_TC = SW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_TC  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_TC = RW'(REPEAT_PERIOD - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic [N_CH-1:0] s1_q, s1_d;
    logic [N_CH-1:0] s2_q, s2_d;
    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] press_q, press_d;
    logic [N_CH-1:0] release_q, release_d;
    logic [N_CH-1:0] repeat_q, repeat_d;
    logic            any_press_q, any_press_d;

    logic [SW-1:0] cnt_q   [N_CH];
    logic [SW-1:0] cnt_d   [N_CH];
    logic [1:0]    state_q [N_CH];
    logic [1:0]    state_d [N_CH];
    logic [RW-1:0] rcnt_q  [N_CH];
    logic [RW-1:0] rcnt_d  [N_CH];

    always_comb begin
        s1_d = btn_i;
        s2_d = s1_q;
    end

    // Stability counter: any cycle where the synchronized input agrees with level restarts the run.
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == STABLE_TC) begin
                    level_d[i]   = ~level_q[i];
                    press_d[i]   = ~level_q[i];
                    release_d[i] = level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + SW'(1);
                end
            end
        end
    end

    // Repeat FSM; a release in the same cycle overrides any terminal count.
    always_comb begin
        repeat_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            rcnt_d[i]  = rcnt_q[i] + RW'(1);
            case (state_q[i])
                ST_IDLE: begin
                    rcnt_d[i] = '0;
                    if (press_d[i]) begin
                        state_d[i] = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (rcnt_q[i] == DELAY_TC) begin
                        repeat_d[i] = 1'b1;
                        rcnt_d[i]   = '0;
                        state_d[i]  = ST_REPEAT;
                    end
                end
                ST_REPEAT: begin
                    if (rcnt_q[i] == PERIOD_TC) begin
                        repeat_d[i] = 1'b1;
                        rcnt_d[i]   = '0;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    rcnt_d[i]  = '0;
                end
            endcase
            if (release_d[i] || (REPEAT_EN == 0)) begin
                state_d[i]  = ST_IDLE;
                rcnt_d[i]   = '0;
                repeat_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        any_press_d = |(press_d | repeat_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            repeat_q    <= '0;
            any_press_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]   <= '0;
                state_q[i] <= ST_IDLE;
                rcnt_q[i]  <= '0;
            end
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
            any_press_q <= any_press_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]   <= cnt_d[i];
                state_q[i] <= state_d[i];
                rcnt_q[i]  <= rcnt_d[i];
            end
        end
    end

    assign level_o     = level_q;
    assign press_o     = press_q;
    assign release_o   = release_q;
    assign repeat_o    = repeat_q;
    assign any_press_o = any_press_q;

endmodule

// File: tb/tb_btn_debounce_array.sv
// Bench for btn_debounce_array: timestamp-based reference model feeds a scoreboard queue,
// a monitor pops one expectation per edge; two DUTs share stimulus (repeat on / off).
module tb_btn_debounce_array;

    localparam int N  = 4;
    localparam int S  = 4;
    localparam int D  = 10;
    localparam int P  = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] btn;

    logic [N-1:0] level_o, press_o, release_o, repeat_o;
    logic         any_press_o;
    logic [N-1:0] level_nr, press_nr, release_nr, repeat_nr;
    logic         any_nr;

    btn_debounce_array #(
        .N_CH(N), .STABLE_CYCLES(S), .REPEAT_EN(1), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
    ) dut (
        .clk(clk), .rst(rst), .btn_i(btn),
        .level_o(level_o), .press_o(press_o), .release_o(release_o),
        .repeat_o(repeat_o), .any_press_o(any_press_o)
    );

    btn_debounce_array #(
        .N_CH(N), .STABLE_CYCLES(S), .REPEAT_EN(0), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
    ) dut_nr (
        .clk(clk), .rst(rst), .btn_i(btn),
        .level_o(level_nr), .press_o(press_nr), .release_o(release_nr),
        .repeat_o(repeat_nr), .any_press_o(any_nr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0]  cyc;
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] rpt;
        logic         any;
        logic         any_nr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int mon_cyc = 0;

    // Reference model state: synchronized copies, accepted level, mismatch run, next repeat time.
    logic [N-1:0] m_s1, m_s2, m_lvl;
    int           m_run  [N];
    int           m_next [N];

    // Event logs gathered by the monitor for directed timing checks.
    int ev_press0[$], ev_rep0[$], ev_rel0[$], ev_rel0_nr[$];
    int ev_pv_edge[$];
    logic [N-1:0] ev_pv_val[$];
    int pcnt [N];
    int rep_nr_total = 0;

    task automatic chk(input string name, input int edge_n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [N-1:0] b, output exp_t e);
        e = '0;
        e.cyc = 32'(cyc);
        if (r) begin
            m_s1 = '0;
            m_s2 = '0;
            m_lvl = '0;
            for (int ch = 0; ch < N; ch++) begin
                m_run[ch]  = 0;
                m_next[ch] = -1;
            end
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                if (m_s2[ch] != m_lvl[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == S) begin
                        m_lvl[ch] = ~m_lvl[ch];
                        m_run[ch] = 0;
                        if (m_lvl[ch]) begin
                            e.press[ch] = 1'b1;
                            m_next[ch]  = cyc + D;
                        end else begin
                            e.rel[ch]  = 1'b1;
                            m_next[ch] = -1;
                        end
                    end
                end else begin
                    m_run[ch] = 0;
                end
                if (m_next[ch] == cyc) begin
                    e.rpt[ch]  = 1'b1;
                    m_next[ch] = cyc + P;
                end
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
        e.level  = m_lvl;
        e.any    = |(e.press | e.rpt);
        e.any_nr = |e.press;
    endtask

    task automatic drive(input logic r, input logic [N-1:0] b);
        exp_t e;
        cyc++;
        rst = r;
        btn = b;
        model_step(r, b, e);
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        ev_press0.delete();
        ev_rep0.delete();
        ev_rel0.delete();
        ev_rel0_nr.delete();
        ev_pv_edge.delete();
        ev_pv_val.delete();
    endtask

    // Monitor: samples 4 time units after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            mon_cyc++;
            #4;
            if (press_o[0])    ev_press0.push_back(mon_cyc);
            if (repeat_o[0])   ev_rep0.push_back(mon_cyc);
            if (release_o[0])  ev_rel0.push_back(mon_cyc);
            if (release_nr[0]) ev_rel0_nr.push_back(mon_cyc);
            if (press_o != '0) begin
                ev_pv_edge.push_back(mon_cyc);
                ev_pv_val.push_back(press_o);
            end
            for (int ch = 0; ch < N; ch++) if (press_o[ch]) pcnt[ch]++;
            if (repeat_nr != '0) rep_nr_total++;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("level",      mon_cyc, 32'(level_o),     32'(mon_e.level));
                chk("press",      mon_cyc, 32'(press_o),     32'(mon_e.press));
                chk("release",    mon_cyc, 32'(release_o),   32'(mon_e.rel));
                chk("repeat",     mon_cyc, 32'(repeat_o),    32'(mon_e.rpt));
                chk("any_press",  mon_cyc, 32'(any_press_o), 32'(mon_e.any));
                chk("nr_level",   mon_cyc, 32'(level_nr),    32'(mon_e.level));
                chk("nr_press",   mon_cyc, 32'(press_nr),    32'(mon_e.press));
                chk("nr_release", mon_cyc, 32'(release_nr),  32'(mon_e.rel));
                chk("nr_repeat",  mon_cyc, 32'(repeat_nr),   32'd0);
                chk("nr_any",     mon_cyc, 32'(any_nr),      32'(mon_e.any_nr));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog @edge %0d: got timeout expected completion", mon_cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int p0;
        logic [N-1:0] rb;
        for (int ch = 0; ch < N; ch++) pcnt[ch] = 0;

        repeat (3) drive(1'b1, 4'b0000);
        repeat (2) drive(1'b0, 4'b0000);

        // Press and hold channel 0; release so the release lands between repeats.
        clear_logs();
        base = cyc;
        repeat (30) drive(1'b0, 4'b0001);
        repeat (12) drive(1'b0, 4'b0000);
        chk("s1_press_cnt", cyc, ev_press0.size(), 1);
        chk("s1_rep_cnt",   cyc, ev_rep0.size(), 7);
        chk("s1_rel_cnt",   cyc, ev_rel0.size(), 1);
        if (ev_press0.size() == 1) begin
            chk("s1_press_edge", cyc, ev_press0[0] - base, 6);
            for (int k = 0; k < ev_rep0.size() && k < 7; k++)
                chk("s1_rep_edge", cyc, ev_rep0[k] - ev_press0[0], 10 + 3 * k);
            if (ev_rel0.size() == 1)
                chk("s1_rel_edge", cyc, ev_rel0[0] - ev_press0[0], 30);
            if (ev_rel0_nr.size() == 1)
                chk("s1_nr_rel_edge", cyc, ev_rel0_nr[0] - ev_press0[0], 30);
        end

        // Three-cycle glitch on channel 1 must be ignored.
        p0 = pcnt[1];
        repeat (3) drive(1'b0, 4'b0010);
        repeat (8) drive(1'b0, 4'b0000);
        chk("glitch_press1", cyc, pcnt[1] - p0, 0);

        // Channels 2 and 3 rise together.
        clear_logs();
        base = cyc;
        repeat (8) drive(1'b0, 4'b1100);
        repeat (10) drive(1'b0, 4'b0000);
        chk("dual_press_cnt", cyc, ev_pv_edge.size(), 1);
        if (ev_pv_edge.size() == 1) begin
            chk("dual_press_edge", cyc, ev_pv_edge[0] - base, 6);
            chk("dual_press_vec",  cyc, 32'(ev_pv_val[0]), 32'hC);
        end

        // Reset while channel 0 is mid-count, button kept high.
        clear_logs();
        repeat (4) drive(1'b0, 4'b0001);
        drive(1'b1, 4'b0001);
        base = cyc;
        repeat (10) drive(1'b0, 4'b0001);
        repeat (10) drive(1'b0, 4'b0000);
        chk("rst_press_cnt", cyc, ev_press0.size(), 1);
        if (ev_press0.size() == 1)
            chk("rst_press_edge", cyc, ev_press0[0] - base, 6);

        // Release coinciding with a repeat terminal count: release wins.
        clear_logs();
        repeat (31) drive(1'b0, 4'b0001);
        repeat (12) drive(1'b0, 4'b0000);
        chk("coin_rep_cnt", cyc, ev_rep0.size(), 7);
        if (ev_press0.size() == 1 && ev_rel0.size() == 1)
            chk("coin_rel_edge", cyc, ev_rel0[0] - ev_press0[0], 31);
        else
            chk("coin_events", cyc, 32'(ev_press0.size() + ev_rel0.size()), 32'd2);

        // Randomized segments alternating chattery and long-hold behaviour.
        rb = '0;
        for (int seg = 0; seg < 20; seg++) begin
            int lim;
            lim = ($urandom_range(0, 1) == 0) ? 2 : 30;
            for (int c = 0; c < 40; c++) begin
                for (int ch = 0; ch < N; ch++)
                    if ($urandom_range(0, lim) == 0) rb[ch] = ~rb[ch];
                drive(($urandom_range(0, 199) == 0), rb);
            end
        end
        repeat (12) drive(1'b0, 4'b0000);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #5;
        chk("sb_drained", cyc, sb_q.size(), 0);
        chk("nr_repeat_total", cyc, rep_nr_total, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_debounce_array.md
BTN_DEBOUNCE_ARRAY -- requirements
Module: btn_debounce_array

Interface
REQ-001 Parameter N_CH, default 5: number of independent button channels, range 1..32.
REQ-002 Parameter STABLE_CYCLES, default 500000: consecutive synchronized-mismatch cycles required to accept a new level, range 2..2^24.
REQ-003 Parameter REPEAT_EN, default 0: 1 enables auto-repeat pulses on held channels; 0 ties repeat_o to 0.
REQ-004 Parameter REPEAT_DELAY, default 50000000: cycles from press_o pulse to first repeat_o pulse, range 2..2^28.
REQ-005 Parameter REPEAT_PERIOD, default 10000000: cycles between successive repeat_o pulses, range 2..2^28.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 btn_i  input  N_CH  raw asynchronous button levels, 1 = pressed.
REQ-009 level_o  output  N_CH  debounced registered level per channel.
REQ-010 press_o  output  N_CH  one-cycle pulse on accepted 0->1 transition.
REQ-011 release_o  output  N_CH  one-cycle pulse on accepted 1->0 transition.
REQ-012 repeat_o  output  N_CH  one-cycle auto-repeat pulse while held.
REQ-013 any_press_o  output  1  registered OR of press_o and repeat_o, aligned with them.

Function
REQ-014 Each channel passes btn_i through a 2-flop synchronizer (s1, s2) before any other use; channels share no state.
REQ-015 Stability counter width = clog2(STABLE_CYCLES); counter increments each cycle s2 != level, clears each cycle s2 == level.
REQ-016 When s2 != level and counter == STABLE_CYCLES-1: level toggles, counter clears, press_o (new level 1) or release_o (new level 0) asserts for exactly that one cycle.
REQ-017 Latency: btn_i settled before edge 1 -> level_o and pulse update at edge STABLE_CYCLES+2; any mismatch run shorter than STABLE_CYCLES cycles leaves level_o unchanged and produces no pulse.
REQ-018 Button held indefinitely yields exactly one press_o; no pulse ever repeats from the debounce path (successor behaviour: press-once, release-once).
REQ-019 Repeat FSM per channel (REPEAT_EN=1): IDLE -> DELAY on press_o; DELAY -> REPEAT after REPEAT_DELAY cycles, issuing repeat_o; REPEAT issues repeat_o every REPEAT_PERIOD cycles; any state -> IDLE when level_o falls.
REQ-020 Repeat counter width = clog2(max(REPEAT_DELAY, REPEAT_PERIOD)); counter clears on every state entry and on each repeat_o.
REQ-021 repeat_o never asserts in the same cycle as press_o or release_o of that channel; release wins over a coincident repeat terminal count.
REQ-022 Simultaneous events on different channels are independent; any_press_o is 1 if any channel pulses that cycle.
REQ-023 press_o, release_o, repeat_o, any_press_o are registered outputs; no combinational path from btn_i.

Reset
REQ-024 rst=1 at an edge clears s1, s2, level_o, press_o, release_o, repeat_o, any_press_o, all counters, and all repeat FSMs to IDLE.
REQ-025 Reset mid-count or mid-repeat discards progress; no pulse is emitted in the cycle rst is high or on the first edge after deassertion.
REQ-026 Button held through reset: press_o asserts at edge STABLE_CYCLES+2 after the first edge with rst=0.

Verification (bench: N_CH=4, STABLE_CYCLES=4, REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-027 btn_i[0] 0->1 held -> level_o[0]=1 and press_o[0]=1 for one cycle at edge 6; any_press_o=1 same cycle.
REQ-028 btn_i[1] glitch high 3 cycles then low -> level_o[1] stays 0, no pulses.
REQ-029 btn_i[0] held 30 cycles after press -> repeat_o[0] at press+10, +13, +16, +19, +22, +25, +28; then released -> release_o[0] at edge 6 after release, no repeat_o after it.
REQ-030 btn_i[2] and btn_i[3] rise same cycle -> press_o=4'b1100 at edge 6, any_press_o single-cycle 1.
REQ-031 rst asserted while channel 0 counter=2 -> all outputs 0; btn_i[0] still high -> press_o[0] at edge 6 after rst falls.
REQ-032 REPEAT_EN=0 rerun of REQ-029 stimulus -> repeat_o stays 0, press/release timing unchanged.
